// File: rtl/hopper_ctrl.sv
// hopper_ctrl: frame-rate sprite controller for a lane-crossing game (hop, ride, death, win, respawn).
// Define HOPPER_LIVES_EN to enable the lives counter and the sticky game-over state.
module hopper_ctrl #(
    parameter int NUM_LANES  = 4,
    parameter int X_MAX      = 640,
    parameter int Y_MAX      = 480,
    parameter int SPR_W      = 40,
    parameter int SPR_H      = 40,
    parameter int STEP_X     = 20,
    parameter int STEP_Y     = 40,
    parameter int HOP_FRAMES = 4,
    parameter int RIDE_STEP  = 20,
    parameter int RIVER_Y_LO = 80,
    parameter int RIVER_Y_HI = 200,
    parameter int LIVES      = 3
) (
    input  logic                   frame_clk,
    input  logic                   Reset_n,
    input  logic [10:0]            x_start,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic                   active,
    input  logic [NUM_LANES-1:0]   lane_coll,
    input  logic [NUM_LANES-1:0]   lane_dir,
    input  logic [NUM_LANES*6-1:0] lane_period,
    input  logic [NUM_LANES-1:0]   car_coll,
    input  logic                   goal_hit,
    output logic [10:0]            pos_x,
    output logic [10:0]            pos_y,
    output logic [1:0]             facing,
    output logic                   hopping,
    output logic                   dead_pulse,
    output logic                   win_pulse,
    output logic [1:0]             lives,
    output logic                   game_over
);
    localparam int          LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [10:0] X_LIM    = 11'(X_MAX - SPR_W);
    localparam logic [10:0] Y_LIM    = 11'(Y_MAX - SPR_H);
    localparam logic [10:0] SX       = 11'(STEP_X);
    localparam logic [10:0] SY       = 11'(STEP_Y);
    localparam logic [10:0] DX       = 11'(STEP_X / HOP_FRAMES);
    localparam logic [10:0] DY       = 11'(STEP_Y / HOP_FRAMES);
    localparam logic [10:0] RS       = 11'(RIDE_STEP);
    localparam logic [10:0] R_LO     = 11'(RIVER_Y_LO);
    localparam logic [10:0] R_HI     = 11'(RIVER_Y_HI);
    localparam logic [7:0]  HOP_LAST = 8'(HOP_FRAMES - 1);

    localparam logic [1:0] F_UP    = 2'b00;
    localparam logic [1:0] F_DOWN  = 2'b01;
    localparam logic [1:0] F_LEFT  = 2'b11;
    localparam logic [1:0] F_RIGHT = 2'b10;

    typedef enum logic [2:0] {IDLE, HOP, KEYWAIT, RIDE, DEAD, WIN, RESPAWN, OVER} state_t;

    state_t        state, state_n;
    logic [10:0]   px_n, py_n, x_home, ride_x;
    logic [1:0]    face_n, key_face;
    logic [7:0]    hop_cnt, hop_cnt_n;
    logic [5:0]    ride_cnt, ride_cnt_n, low_period;
    logic [LW-1:0] ride_lane, ride_lane_n, low_lane;
    logic          dying, key_any, key_go, tgt_ok;

    assign x_home  = (x_start > X_LIM) ? X_LIM : x_start;
    assign key_any = up | down | left | right;
    assign key_go  = active & key_any;
    assign dying   = (|car_coll) || (pos_y >= R_LO && pos_y <= R_HI && !(|lane_coll));

    assign hopping    = (state == HOP);
    assign dead_pulse = (state == DEAD);
    assign win_pulse  = (state == WIN);

`ifdef HOPPER_LIVES_EN
    logic [1:0] lives_q;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n)
            lives_q <= 2'(LIVES);
        else if (state == DEAD)
            lives_q <= lives_q - 2'd1;
    end

    assign lives     = lives_q;
    assign game_over = (state == OVER);
`else
    assign lives     = 2'(LIVES);
    assign game_over = 1'b0;
`endif

    always_comb begin
        low_lane = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++)
            if (lane_coll[NUM_LANES-1-i]) low_lane = LW'(NUM_LANES - 1 - i);
    end

    assign low_period = lane_period[int'(low_lane)*6 +: 6];

    always_comb begin
        if (lane_dir[low_lane])
            ride_x = (pos_x > X_LIM - RS) ? X_LIM : pos_x + RS;
        else
            ride_x = (pos_x < RS) ? '0 : pos_x - RS;
    end

    always_comb begin
        key_face = F_RIGHT;
        if (down)      key_face = F_DOWN;
        else if (up)   key_face = F_UP;
        else if (left) key_face = F_LEFT;
        case (key_face)
            F_UP:    tgt_ok = (pos_y >= SY);
            F_DOWN:  tgt_ok = ({1'b0, pos_y} + {1'b0, SY}) <= {1'b0, Y_LIM};
            F_LEFT:  tgt_ok = (pos_x >= SX);
            default: tgt_ok = ({1'b0, pos_x} + {1'b0, SX}) <= {1'b0, X_LIM};
        endcase
    end

    always_comb begin
        state_n     = state;
        px_n        = pos_x;
        py_n        = pos_y;
        face_n      = facing;
        hop_cnt_n   = hop_cnt;
        ride_cnt_n  = ride_cnt;
        ride_lane_n = ride_lane;
        case (state)
            IDLE, RIDE: begin
                if (dying)
                    state_n = DEAD;
                else if (goal_hit)
                    state_n = WIN;
                else if (key_go) begin
                    face_n    = key_face;
                    hop_cnt_n = '0;
                    state_n   = tgt_ok ? HOP : KEYWAIT;
                end else if (|lane_coll) begin
                    state_n = RIDE;
                    // a fresh ride or a switch to another lane restarts the move cadence
                    if (state == IDLE || low_lane != ride_lane) begin
                        ride_cnt_n  = '0;
                        ride_lane_n = low_lane;
                    end else if (low_period != '0) begin
                        if (ride_cnt == low_period - 6'd1) begin
                            px_n       = ride_x;
                            ride_cnt_n = '0;
                        end else
                            ride_cnt_n = ride_cnt + 6'd1;
                    end
                end else
                    state_n = IDLE;
            end
            HOP: begin
                case (facing)
                    F_UP:    py_n = pos_y - DY;
                    F_DOWN:  py_n = pos_y + DY;
                    F_LEFT:  px_n = pos_x - DX;
                    default: px_n = pos_x + DX;
                endcase
                hop_cnt_n = hop_cnt + 8'd1;
                if (hop_cnt == HOP_LAST) begin
                    hop_cnt_n = '0;
                    state_n   = KEYWAIT;
                end
            end
            KEYWAIT: begin
                if (dying)         state_n = DEAD;
                else if (goal_hit) state_n = WIN;
                else if (!key_any) state_n = IDLE;
            end
            DEAD: begin
`ifdef HOPPER_LIVES_EN
                state_n = (lives_q == 2'd1) ? OVER : RESPAWN;
`else
                state_n = RESPAWN;
`endif
            end
            WIN:     state_n = RESPAWN;
            RESPAWN: begin
                px_n    = x_home;
                py_n    = Y_LIM;
                face_n  = F_UP;
                state_n = IDLE;
            end
            OVER:    state_n = OVER;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pos_x     <= x_home;
            pos_y     <= Y_LIM;
            facing    <= F_UP;
            hop_cnt   <= '0;
            ride_cnt  <= '0;
            ride_lane <= '0;
        end else begin
            state     <= state_n;
            pos_x     <= px_n;
            pos_y     <= py_n;
            facing    <= face_n;
            hop_cnt   <= hop_cnt_n;
            ride_cnt  <= ride_cnt_n;
            ride_lane <= ride_lane_n;
        end
    end

endmodule

// File: tb/tb_hopper_ctrl.sv
// tb_hopper_ctrl: directed scenarios for hopper_ctrl checked every frame against a scheduling model.
module tb_hopper_ctrl;
    localparam int NL = 4;
    localparam int XL = 600;
    localparam int YL = 440;
`ifdef HOPPER_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif
    localparam int EXP_L1    = LIVES_EN ? 2 : 3;
    localparam int EXP_L_END = LIVES_EN ? 0 : 3;
    localparam int EXP_GO    = LIVES_EN ? 1 : 0;
    localparam int EXP_Y_END = LIVES_EN ? 440 : 400;

    logic            frame_clk   = 1'b0;
    logic            Reset_n     = 1'b0;
    logic [10:0]     x_start     = 11'd300;
    logic            up          = 1'b0;
    logic            down        = 1'b0;
    logic            left        = 1'b0;
    logic            right       = 1'b0;
    logic            active      = 1'b1;
    logic [NL-1:0]   lane_coll   = '0;
    logic [NL-1:0]   lane_dir    = '0;
    logic [NL*6-1:0] lane_period = '0;
    logic [NL-1:0]   car_coll    = '0;
    logic            goal_hit    = 1'b0;
    logic [10:0]     pos_x, pos_y;
    logic [1:0]      facing, lives;
    logic            hopping, dead_pulse, win_pulse, game_over;

    hopper_ctrl #(.NUM_LANES(NL)) dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .x_start(x_start),
        .up(up), .down(down), .left(left), .right(right), .active(active),
        .lane_coll(lane_coll), .lane_dir(lane_dir), .lane_period(lane_period),
        .car_coll(car_coll), .goal_hit(goal_hit),
        .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .hopping(hopping),
        .dead_pulse(dead_pulse), .win_pulse(win_pulse), .lives(lives), .game_over(game_over)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: hops are a queue of future positions, death/win are queues of pending actions.
    int m_x, m_y, m_face, m_lives, m_lane, m_cnt;
    bit m_hop, m_dead, m_win, m_over, m_wait, m_riding;
    int path_x[$], path_y[$];
    int sched[$];

    task automatic model_reset();
        m_x = int'(x_start); m_y = YL; m_face = 0; m_lives = 3;
        m_hop = 0; m_dead = 0; m_win = 0; m_over = 0; m_wait = 0; m_riding = 0;
        m_lane = 0; m_cnt = 0;
        path_x.delete(); path_y.delete(); sched.delete();
    endtask

    function automatic int lowest(input logic [NL-1:0] v);
        for (int i = 0; i < NL; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        int dx, dy, tx, ty, p, a;
        m_dead = 0; m_win = 0;
        if (m_over) return;
        if (sched.size() != 0) begin
            a = sched.pop_front();
            if (a == 1) begin
                if (LIVES_EN) m_lives--;
                if (m_lives == 0) m_over = 1; else sched.push_back(2);
            end else if (a == 2) begin
                m_x = int'(x_start); m_y = YL; m_face = 0;
            end
            return;
        end
        if (path_x.size() != 0) begin
            m_x = path_x.pop_front(); m_y = path_y.pop_front();
            m_hop = (path_x.size() != 0);
            if (!m_hop) m_wait = 1;
            return;
        end
        if ((car_coll != 0) || (m_y >= 80 && m_y <= 200 && lane_coll == 0)) begin
            m_dead = 1; sched.push_back(1); m_riding = 0; m_wait = 0;
            return;
        end
        if (goal_hit) begin
            m_win = 1; sched.push_back(0); sched.push_back(2); m_riding = 0; m_wait = 0;
            return;
        end
        if (m_wait) begin
            if (!(up | down | left | right)) m_wait = 0;
            return;
        end
        if (active && (up | down | left | right)) begin
            m_riding = 0;
            if (down)      begin m_face = 1; dx = 0;   dy = 40;  end
            else if (up)   begin m_face = 0; dx = 0;   dy = -40; end
            else if (left) begin m_face = 3; dx = -20; dy = 0;   end
            else           begin m_face = 2; dx = 20;  dy = 0;   end
            tx = m_x + dx; ty = m_y + dy;
            if (tx < 0 || tx > XL || ty < 0 || ty > YL) m_wait = 1;
            else begin
                m_hop = 1;
                for (int k = 1; k <= 4; k++) begin
                    path_x.push_back(m_x + dx * k / 4);
                    path_y.push_back(m_y + dy * k / 4);
                end
            end
            return;
        end
        if (lane_coll != 0) begin
            if (!m_riding || lowest(lane_coll) != m_lane) begin
                m_riding = 1; m_lane = lowest(lane_coll); m_cnt = 0;
            end else begin
                p = int'(lane_period[m_lane*6 +: 6]);
                if (p != 0) begin
                    m_cnt++;
                    if (m_cnt == p) begin
                        m_cnt = 0;
                        m_x += lane_dir[m_lane] ? 20 : -20;
                        if (m_x > XL) m_x = XL;
                        if (m_x < 0) m_x = 0;
                    end
                end
            end
            return;
        end
        m_riding = 0;
    endtask

    initial forever begin
        @(posedge frame_clk or negedge Reset_n);
        if (!Reset_n) model_reset(); else model_step();
    end

    initial forever begin
        @(negedge frame_clk);
        check("pos_x", int'(pos_x), m_x);
        check("pos_y", int'(pos_y), m_y);
        check("facing", int'(facing), m_face);
        check("hopping", int'(hopping), int'(m_hop));
        check("dead_pulse", int'(dead_pulse), int'(m_dead));
        check("win_pulse", int'(win_pulse), int'(m_win));
        check("lives", int'(lives), m_lives);
        check("game_over", int'(game_over), int'(m_over));
    end

    task automatic frames(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic keys(input logic u, input logic d, input logic l, input logic r);
        up = u; down = d; left = l; right = r;
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r, input int hold);
        keys(u, d, l, r);
        frames(hold);
        keys(1'b0, 1'b0, 1'b0, 1'b0);
        frames(8);
    endtask

    initial begin
        frames(2);
        check("rst_x", int'(pos_x), 300);
        check("rst_y", int'(pos_y), 440);
        check("rst_lives", int'(lives), 3);
        check("rst_face", int'(facing), 0);
        check("rst_hop", int'(hopping), 0);
        Reset_n = 1'b1;
        frames(2);

        up = 1'b1;
        frames(1);
        check("hop_entry_y", int'(pos_y), 440);
        check("hop_entry_h", int'(hopping), 1);
        up = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            frames(1);
            check("hop_y", int'(pos_y), 440 - 10 * k);
            check("hop_h", int'(hopping), int'(k < 4));
        end
        frames(4);

        press(1'b1, 1'b0, 1'b0, 1'b0, 8);
        check("keywait_y", int'(pos_y), 360);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        lane_coll = 4'b0001;
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        check("river_y", int'(pos_y), 120);

        lane_period[2*6 +: 6] = 6'd3;
        lane_dir[2] = 1'b1;
        lane_coll = 4'b0100;
        for (int k = 1; k <= 54; k++) begin
            frames(1);
            check("ride_x", int'(pos_x), (300 + 20 * ((k - 1) / 3) > 600) ? 600 : 300 + 20 * ((k - 1) / 3));
        end

        right = 1'b1;
        frames(1);
        check("edge_face", int'(facing), 2);
        check("edge_x", int'(pos_x), 600);
        check("edge_hop", int'(hopping), 0);
        right = 1'b0;
        frames(6);

        lane_coll = '0;
        frames(1);
        check("drown_pulse", int'(dead_pulse), 1);
        frames(1);
        check("drown_pulse_end", int'(dead_pulse), 0);
        check("drown_lives", int'(lives), EXP_L1);
        frames(1);
        check("respawn_x", int'(pos_x), 300);
        check("respawn_y", int'(pos_y), 440);
        check("respawn_face", int'(facing), 0);
        frames(2);

        goal_hit = 1'b1;
        frames(1);
        check("win_pulse_lit", int'(win_pulse), 1);
        goal_hit = 1'b0;
        frames(4);

        keys(1'b1, 1'b0, 1'b1, 1'b0);
        frames(1);
        check("prio_face", int'(facing), 0);
        check("prio_hop", int'(hopping), 1);
        keys(1'b0, 1'b0, 1'b0, 1'b0);
        frames(8);
        check("prio_y", int'(pos_y), 400);
        check("prio_x", int'(pos_x), 300);

        car_coll = 4'b0001;
        goal_hit = 1'b1;
        frames(1);
        check("both_dead", int'(dead_pulse), 1);
        check("both_win", int'(win_pulse), 0);
        car_coll = '0;
        goal_hit = 1'b0;
        frames(5);

        car_coll = 4'b0010;
        frames(1);
        check("car_dead", int'(dead_pulse), 1);
        car_coll = '0;
        frames(3);
        check("end_lives", int'(lives), EXP_L_END);
        check("end_over", int'(game_over), EXP_GO);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        check("over_keys_y", int'(pos_y), EXP_Y_END);
        check("over_sticky", int'(game_over), EXP_GO);

        frames(2);
        up = 1'b1;
        frames(1);
        up = 1'b0;
        frames(2);
        #2 Reset_n = 1'b0;
        frames(1);
        check("abort_y", int'(pos_y), 440);
        check("abort_hop", int'(hopping), 0);
        check("abort_over", int'(game_over), 0);
        Reset_n = 1'b1;
        frames(6);
        check("after_abort_y", int'(pos_y), 440);
        check("after_abort_x", int'(pos_x), 300);
        check("after_abort_lives", int'(lives), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hopper_ctrl.md
HOPPER_CTRL -- requirements
Module: hopper_ctrl

Interface
REQ-001 The module SHALL expose these parameters, one per line as name, default, meaning:
  NUM_LANES  4  ride lanes (platform channels)
  X_MAX  640  playfield width, pixels
  Y_MAX  480  playfield height, pixels
  SPR_W  40  sprite width
  SPR_H  40  sprite height
  STEP_X  20  horizontal hop distance
  STEP_Y  40  vertical hop distance
  HOP_FRAMES  4  frames per hop; STEP_X and STEP_Y SHALL be divisible by it
  RIDE_STEP  20  pixels per ride move
  RIVER_Y_LO  80  river band top (inclusive)
  RIVER_Y_HI  200  river band bottom (inclusive)
  LIVES  3  starting lives, 1..3
REQ-002 The module SHALL have these ports, one per line as name, direction, width, meaning:
  frame_clk  in  1  single clock, one edge per video frame
  Reset_n  in  1  asynchronous, active-low reset
  x_start  in  11  respawn X
  up, down, left, right  in  1 each  key levels
  active  in  1  keys enabled
  lane_coll  in  NUM_LANES  sprite overlaps platform i
  lane_dir  in  NUM_LANES  1 = right, 0 = left
  lane_period  in  NUM_LANES*6  frames per ride move for lane i; 0 = stationary
  car_coll  in  NUM_LANES  sprite overlaps hazard i
  goal_hit  in  1  sprite in goal slot
  pos_x, pos_y  out  11  sprite top-left
  facing  out  2  00 up, 01 down, 11 left, 10 right
  hopping  out  1  hop in progress
  dead_pulse, win_pulse  out  1  one-frame event strobes
  lives  out  2  remaining lives
  game_over  out  1  no lives left

Function
REQ-003 The FSM SHALL have the states IDLE, HOP, KEYWAIT, RIDE, DEAD, WIN, RESPAWN and OVER.
REQ-004 The FSM SHALL evaluate IDLE and RIDE in this priority order: death (any car_coll, or pos_y in [RIVER_Y_LO, RIVER_Y_HI] with no lane_coll) -> DEAD; goal_hit -> WIN; key with active=1 -> HOP; any lane_coll -> RIDE; else IDLE.
REQ-005 When several keys are pressed together, the FSM SHALL select the key by priority down > up > left > right, and SHALL set facing on HOP entry.
REQ-006 On HOP entry the FSM SHALL compute the target; if the target lies outside x in [0, X_MAX-SPR_W] or y in [0, Y_MAX-SPR_H], the FSM SHALL set facing only and go to KEYWAIT without moving.
REQ-007 In HOP the block SHALL move the sprite STEP/HOP_FRAMES per frame for exactly HOP_FRAMES frames, hold hopping=1, and go to KEYWAIT on the last frame.
REQ-008 The block SHALL NOT check death, goal or ride while in HOP.
REQ-009 KEYWAIT SHALL wait for all keys to be released before returning to IDLE; death and goal SHALL be checked in KEYWAIT with the same priority as IDLE.
REQ-010 In RIDE the block SHALL use the lowest-index asserted lane_coll bit as the ride lane.
REQ-011 In RIDE the block SHALL hold a 6-bit frame counter and, when the counter equals lane_period[i]-1, move RIDE_STEP in lane_dir[i] and clear the counter.
REQ-012 When a ride move would cross an edge, the block SHALL clamp the position to 0 or X_MAX-SPR_W.
REQ-013 When lane_period[i]=0, the block SHALL make no ride moves.
REQ-014 The block SHALL clear the ride counter whenever it enters RIDE and whenever the ride lane index changes.
REQ-015 DEAD SHALL last one frame: dead_pulse=1, lives decrements; next state is OVER if lives becomes 0, else RESPAWN.
REQ-016 WIN SHALL last one frame: win_pulse=1; next state RESPAWN.
REQ-017 RESPAWN SHALL set pos=(x_start, Y_MAX-SPR_H) and facing=00, then go to IDLE.
REQ-018 OVER SHALL hold game_over=1 and ignore all inputs until reset.
REQ-019 The block SHALL keep all position arithmetic 11-bit unsigned and SHALL never output a position outside the playfield.

Reset
REQ-020 Reset_n=0 SHALL force, asynchronously: state=IDLE, pos_x=x_start, pos_y=Y_MAX-SPR_H, facing=00, hopping=0, dead_pulse=0, win_pulse=0, lives=LIVES, game_over=0, and all counters=0.
REQ-021 An assertion of Reset_n mid-hop or mid-ride SHALL abort the hop or ride with no residual motion after release.

Configuration
REQ-022 Macro HOPPER_LIVES_EN SHALL control the lives feature.
REQ-023 With HOPPER_LIVES_EN defined, the block SHALL implement the lives counter and OVER as specified above.
REQ-024 Without HOPPER_LIVES_EN, DEAD SHALL always go to RESPAWN, lives SHALL be a constant LIVES, game_over SHALL be a constant 0, and OVER SHALL be unreachable.

Verification
REQ-025 The bench SHALL cover these scenarios:
  Reset with x_start=300, then up held 1 frame -> pos_y 440,430,420,410,400 over 4 frames; hopping=1 for 4 frames; KEYWAIT until release.
  pos_x=600, right pressed -> facing=10, pos_x stays 600, no hop.
  pos_y=120, lane_coll[2]=1, lane_period[2]=3, lane_dir[2]=1 -> pos_x +20 every 3rd frame; clamps at 600.
  pos_y=120, lane_coll all 0 -> dead_pulse one frame, lives 3->2, then respawn at (x_start, 440).
  Three deaths -> lives=0, game_over=1 sticky, keys ignored; without HOPPER_LIVES_EN -> game_over stays 0.
  car_coll and goal_hit asserted together -> DEAD wins; left+up pressed together -> up hop taken.
